// File: rtl/dest_reg_hazard_unit.sv
// dest_reg_hazard_unit
// Carries the selected destination register and its RegWrite/MemRead
// qualifiers from ID through EX, MEM and WB. From those copies it derives
// the EX operand forwarding selects, the ID register-file bypass selects,
// the load-use stall and the register-file write port.
module dest_reg_hazard_unit (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [4:0] WriteReg_ID,
    input  logic       RegWrite_ID,
    input  logic       MemRead_ID,
    input  logic [4:0] Rs_ID,
    input  logic [4:0] Rt_ID,
    input  logic       Flush,
    output logic       Stall,
    output logic [1:0] ForwardA,
    output logic [1:0] ForwardB,
    output logic       BypassA_ID,
    output logic       BypassB_ID,
    output logic [4:0] MEM_WriteReg,
    output logic [4:0] WB_WriteReg,
    output logic       WB_RegWrite
);

    // A stage "produces" a source register when it writes a non-zero
    // register whose number matches; register 0 never matches.
    function automatic logic dest_hit(
        input logic       rw,
        input logic [4:0] wr,
        input logic [4:0] src
    );
        return rw && (wr != 5'd0) && (wr == src);
    endfunction

    // Forward select for one EX operand; the younger MEM result wins over WB.
    function automatic logic [1:0] fwd_sel(
        input logic       mem_rw,
        input logic [4:0] mem_wr,
        input logic       wb_rw,
        input logic [4:0] wb_wr,
        input logic [4:0] src
    );
        logic [1:0] sel;
        if (dest_hit(mem_rw, mem_wr, src)) begin
            sel = 2'b10;
        end else if (dest_hit(wb_rw, wb_wr, src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Pipeline registers
    logic [4:0] ex_wr_q,  ex_wr_d;
    logic       ex_rw_q,  ex_rw_d;
    logic       ex_mr_q,  ex_mr_d;
    logic [4:0] ex_rs_q,  ex_rs_d;
    logic [4:0] ex_rt_q,  ex_rt_d;
    logic [4:0] mem_wr_q, mem_wr_d;
    logic       mem_rw_q, mem_rw_d;
    logic [4:0] wb_wr_q,  wb_wr_d;
    logic       wb_rw_q,  wb_rw_d;

    logic       stall_s;
    logic       bubble_s;

    // Load-use detection: a load in EX whose destination is read in ID.
    always_comb begin
        stall_s = 1'b0;
        if (ex_mr_q && (dest_hit(ex_rw_q, ex_wr_q, Rs_ID) ||
                        dest_hit(ex_rw_q, ex_wr_q, Rt_ID))) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Next pipeline state: EX takes a bubble on stall or flush (a single
    // bubble when both occur), MEM and WB always advance.
    always_comb begin
        bubble_s = stall_s | Flush;
        ex_wr_d  = 5'd0;
        ex_rw_d  = 1'b0;
        ex_mr_d  = 1'b0;
        ex_rs_d  = 5'd0;
        ex_rt_d  = 5'd0;
        if (bubble_s) begin
            ex_wr_d = 5'd0;
            ex_rw_d = 1'b0;
            ex_mr_d = 1'b0;
            ex_rs_d = 5'd0;
            ex_rt_d = 5'd0;
        end else begin
            ex_wr_d = WriteReg_ID;
            ex_rw_d = RegWrite_ID;
            ex_mr_d = MemRead_ID;
            ex_rs_d = Rs_ID;
            ex_rt_d = Rt_ID;
        end
        mem_wr_d = ex_wr_q;
        mem_rw_d = ex_rw_q;
        wb_wr_d  = mem_wr_q;
        wb_rw_d  = mem_rw_q;
    end

    // Pipeline register bank; reset empties every stage at once.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ex_wr_q  <= 5'd0;
            ex_rw_q  <= 1'b0;
            ex_mr_q  <= 1'b0;
            ex_rs_q  <= 5'd0;
            ex_rt_q  <= 5'd0;
            mem_wr_q <= 5'd0;
            mem_rw_q <= 1'b0;
            wb_wr_q  <= 5'd0;
            wb_rw_q  <= 1'b0;
        end else begin
            ex_wr_q  <= ex_wr_d;
            ex_rw_q  <= ex_rw_d;
            ex_mr_q  <= ex_mr_d;
            ex_rs_q  <= ex_rs_d;
            ex_rt_q  <= ex_rt_d;
            mem_wr_q <= mem_wr_d;
            mem_rw_q <= mem_rw_d;
            wb_wr_q  <= wb_wr_d;
            wb_rw_q  <= wb_rw_d;
        end
    end

    // Output decode; purely combinational from pipeline state and ID inputs.
    always_comb begin
        Stall        = stall_s;
        ForwardA     = fwd_sel(mem_rw_q, mem_wr_q, wb_rw_q, wb_wr_q, ex_rs_q);
        ForwardB     = fwd_sel(mem_rw_q, mem_wr_q, wb_rw_q, wb_wr_q, ex_rt_q);
        BypassA_ID   = dest_hit(wb_rw_q, wb_wr_q, Rs_ID);
        BypassB_ID   = dest_hit(wb_rw_q, wb_wr_q, Rt_ID);
        MEM_WriteReg = mem_wr_q;
        WB_WriteReg  = wb_wr_q;
        WB_RegWrite  = wb_rw_q;
    end

endmodule

// File: tb/tb_dest_reg_hazard_unit.sv
// Scoreboard bench for dest_reg_hazard_unit. The driver issues one ID slot
// per cycle and pushes the expected outputs computed from an instruction
// history model; a separate monitor pops and compares every cycle.
module tb_dest_reg_hazard_unit;

    logic       Clk;
    logic       Rst_n;
    logic [4:0] WriteReg_ID;
    logic       RegWrite_ID;
    logic       MemRead_ID;
    logic [4:0] Rs_ID;
    logic [4:0] Rt_ID;
    logic       Flush;
    logic       Stall;
    logic [1:0] ForwardA;
    logic [1:0] ForwardB;
    logic       BypassA_ID;
    logic       BypassB_ID;
    logic [4:0] MEM_WriteReg;
    logic [4:0] WB_WriteReg;
    logic       WB_RegWrite;

    dest_reg_hazard_unit dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .WriteReg_ID(WriteReg_ID), .RegWrite_ID(RegWrite_ID),
        .MemRead_ID(MemRead_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
        .Flush(Flush), .Stall(Stall),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .BypassA_ID(BypassA_ID), .BypassB_ID(BypassB_ID),
        .MEM_WriteReg(MEM_WriteReg), .WB_WriteReg(WB_WriteReg),
        .WB_RegWrite(WB_RegWrite)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // One instruction in flight; a bubble is an all-zero instruction.
    typedef struct packed {
        logic [4:0] wr;
        logic       rw;
        logic       mr;
        logic [4:0] rs;
        logic [4:0] rt;
    } instr_t;

    // hist[0] = instruction in EX, hist[1] = MEM, hist[2] = WB
    instr_t hist [3];

    // {stall, fa, fb, ba, bb, mem_wr, wb_wr, wb_rw}
    logic [17:0] exp_q [$];

    int errors = 0;
    int checks = 0;
    logic stimulus_done = 1'b0;

    function automatic logic produces(input instr_t p, input logic [4:0] r);
        return p.rw && (p.wr != 5'd0) && (p.wr == r);
    endfunction

    function automatic logic [1:0] fwd_exp(input logic [4:0] r);
        if (produces(hist[1], r)) return 2'b10;
        if (produces(hist[2], r)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 3; i++) hist[i] = '0;
    endtask

    // Issue one ID slot: drive inputs between edges, predict outputs, then
    // advance the history at the clock edge.
    task automatic step(input logic rstn, input logic [4:0] wr, input logic rw,
                        input logic mr, input logic [4:0] rs, input logic [4:0] rt,
                        input logic fl);
        logic       st;
        instr_t     id;
        @(negedge Clk);
        #1;
        Rst_n = rstn; WriteReg_ID = wr; RegWrite_ID = rw; MemRead_ID = mr;
        Rs_ID = rs; Rt_ID = rt; Flush = fl;
        if (!rstn) clear_model();
        st = hist[0].mr && (produces(hist[0], rs) || produces(hist[0], rt));
        exp_q.push_back({st, fwd_exp(hist[0].rs), fwd_exp(hist[0].rt),
                         produces(hist[2], rs), produces(hist[2], rt),
                         hist[1].wr, hist[2].wr, hist[2].rw});
        @(posedge Clk);
        if (rstn) begin
            id = '{wr: wr, rw: rw, mr: mr, rs: rs, rt: rt};
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = (st || fl) ? instr_t'('0) : id;
        end else begin
            clear_model();
        end
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    endtask

    // Monitor: compare the DUT against the oldest expectation every cycle.
    initial begin
        logic [17:0] e;
        logic [17:0] a;
        forever begin
            @(negedge Clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {Stall, ForwardA, ForwardB, BypassA_ID, BypassB_ID,
                     MEM_WriteReg, WB_WriteReg, WB_RegWrite};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got stall=%b fa=%b fb=%b ba=%b bb=%b mem=%0d wb=%0d wbrw=%b want stall=%b fa=%b fb=%b ba=%b bb=%b mem=%0d wb=%0d wbrw=%b",
                             $time, a[17], a[16:15], a[14:13], a[12], a[11], a[10:6], a[5:1], a[0],
                             e[17], e[16:15], e[14:13], e[12], e[11], e[10:6], e[5:1], e[0]);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: stimulus_done=%b required 1", stimulus_done);
        $fatal(1, "timeout");
    end

    initial begin
        Rst_n = 1'b0; WriteReg_ID = 5'd0; RegWrite_ID = 1'b0; MemRead_ID = 1'b0;
        Rs_ID = 5'd0; Rt_ID = 5'd0; Flush = 1'b0;
        clear_model();

        // Reset held with random inputs
        for (int i = 0; i < 4; i++)
            step(1'b0, 5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
        // Write r5 reaches WB
        step(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
        nop(4);
        // EX/MEM forward on both operands
        step(1'b1, 5'd8, 1'b1, 1'b0, 5'd1, 5'd2, 1'b0);
        step(1'b1, 5'd10, 1'b1, 1'b0, 5'd8, 5'd8, 1'b0);
        nop(3);
        // MEM/WB forward with one independent instruction between
        step(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
        step(1'b1, 5'd11, 1'b1, 1'b0, 5'd1, 5'd2, 1'b0);
        step(1'b1, 5'd12, 1'b1, 1'b0, 5'd8, 5'd8, 1'b0);
        nop(3);
        // MEM priority over WB
        step(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
        step(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
        step(1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 5'd3, 1'b0);
        nop(3);
        // Register 0 never forwards or stalls
        step(1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
        step(1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
        step(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        nop(3);
        // Load-use: one stall, consumer held and re-presented, then forward
        step(1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
        step(1'b1, 5'd13, 1'b1, 1'b0, 5'd4, 5'd0, 1'b0);
        step(1'b1, 5'd13, 1'b1, 1'b0, 5'd4, 5'd0, 1'b0);
        nop(3);
        // Load whose consumer reads a different register
        step(1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
        step(1'b1, 5'd14, 1'b1, 1'b0, 5'd5, 5'd5, 1'b0);
        nop(3);
        // Load with RegWrite=0 never stalls
        step(1'b1, 5'd4, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0);
        step(1'b1, 5'd14, 1'b1, 1'b0, 5'd4, 5'd4, 1'b0);
        nop(3);
        // Flush kills the write to r9
        step(1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1);
        nop(4);
        // Stall and flush together
        step(1'b1, 5'd6, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
        step(1'b1, 5'd15, 1'b1, 1'b0, 5'd6, 5'd0, 1'b1);
        nop(3);
        // WB bypass of r7 into ID
        step(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
        nop(2);
        step(1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 5'd7, 1'b0);
        nop(2);
        // Async reset mid-stream while MEM holds r6
        step(1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
        step(1'b1, 5'd16, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
        step(1'b0, 5'd17, 1'b1, 1'b0, 5'd6, 5'd6, 1'b0);
        step(1'b1, 5'd0, 1'b0, 1'b0, 5'd6, 5'd16, 1'b0);
        nop(3);
        // Randomized traffic over a small register range to provoke hazards
        for (int i = 0; i < 400; i++) begin
            logic r;
            r = ($urandom_range(0, 49) != 0);
            step(r, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 7) == 0));
        end
        nop(2);
        stimulus_done = 1'b1;
        repeat (2) @(negedge Clk);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
